// File: rtl/inst_ram_loader.sv
// Byte-stream loader for the instruction RAM. It packs received bytes little-endian
// into 32-bit words and writes them over a programmed address window while stalling the CPU.
module inst_ram_loader #(
    parameter int IWIDTH  = 12,
    parameter int TMO_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [IWIDTH-1:0] ld_start_adr,
    input  logic [IWIDTH:0]   ld_word_cnt,
    input  logic              ld_abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [IWIDTH-1:0] ram_wadr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wen,
    output logic              ld_busy,
    output logic              cpu_stall,
    output logic              ld_done,
    output logic              ld_err,
    output logic [31:0]       ld_checksum
);

    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [IWIDTH-1:0] adr_r, adr_nxt_s;
    logic [IWIDTH:0]   rem_r, rem_nxt_s;
    logic [1:0]        idx_r, idx_nxt_s;
    logic [23:0]       part_r, part_nxt_s;
    logic [TW-1:0]     tmo_r, tmo_nxt_s;
    logic [IWIDTH-1:0] wadr_r, wadr_nxt_s;
    logic [31:0]       wdata_r, wdata_nxt_s;
    logic              wen_r, wen_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              err_r, err_nxt_s;
    logic [31:0]       sum_r, sum_nxt_s;
    logic [31:0]       word_s;

    assign word_s = {rx_data, part_r};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-value logic for the datapath and all registered outputs
    always_comb begin
        state_nxt_s = state_r;
        adr_nxt_s   = adr_r;
        rem_nxt_s   = rem_r;
        idx_nxt_s   = idx_r;
        part_nxt_s  = part_r;
        tmo_nxt_s   = tmo_r;
        wadr_nxt_s  = wadr_r;
        wdata_nxt_s = wdata_r;
        wen_nxt_s   = 1'b0;
        done_nxt_s  = (state_r == ST_DONE);
        err_nxt_s   = err_r;
        sum_nxt_s   = sum_r;
        case (state_r)
            ST_IDLE: begin
                if (ld_start) begin
                    adr_nxt_s   = ld_start_adr;
                    rem_nxt_s   = ld_word_cnt;
                    idx_nxt_s   = 2'd0;
                    part_nxt_s  = 24'd0;
                    tmo_nxt_s   = '0;
                    err_nxt_s   = 1'b0;
                    sum_nxt_s   = 32'd0;
                    state_nxt_s = (ld_word_cnt == '0) ? ST_DONE : ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Abort outranks a byte arriving in the same cycle
                if (ld_abort) begin
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = ST_IDLE;
                end else if (rx_valid) begin
                    tmo_nxt_s = '0;
                    if (idx_r == 2'd3) begin
                        wen_nxt_s   = 1'b1;
                        wadr_nxt_s  = adr_r;
                        wdata_nxt_s = word_s;
                        adr_nxt_s   = adr_r + {{(IWIDTH-1){1'b0}}, 1'b1};
                        rem_nxt_s   = rem_r - {{IWIDTH{1'b0}}, 1'b1};
                        sum_nxt_s   = sum_r + word_s;
                        idx_nxt_s   = 2'd0;
                        if (rem_r == {{IWIDTH{1'b0}}, 1'b1}) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_LOAD;
                        end
                    end else begin
                        case (idx_r)
                            2'd0:    part_nxt_s[7:0]   = rx_data;
                            2'd1:    part_nxt_s[15:8]  = rx_data;
                            2'd2:    part_nxt_s[23:16] = rx_data;
                            default: part_nxt_s        = part_r;
                        endcase
                        idx_nxt_s = idx_r + 2'd1;
                    end
                end else if (tmo_r == TW'(TMO_CYC - 1)) begin
                    idx_nxt_s   = 2'd0;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_r   <= '0;
            rem_r   <= '0;
            idx_r   <= 2'd0;
            part_r  <= 24'd0;
            tmo_r   <= '0;
            wadr_r  <= '0;
            wdata_r <= 32'd0;
            wen_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            sum_r   <= 32'd0;
        end else begin
            adr_r   <= adr_nxt_s;
            rem_r   <= rem_nxt_s;
            idx_r   <= idx_nxt_s;
            part_r  <= part_nxt_s;
            tmo_r   <= tmo_nxt_s;
            wadr_r  <= wadr_nxt_s;
            wdata_r <= wdata_nxt_s;
            wen_r   <= wen_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            sum_r   <= sum_nxt_s;
        end
    end

    assign ram_wadr    = wadr_r;
    assign ram_wdata   = wdata_r;
    assign ram_wen     = wen_r;
    assign ld_busy     = busy_r;
    assign cpu_stall   = busy_r;
    assign ld_done     = done_r;
    assign ld_err      = err_r;
    assign ld_checksum = sum_r;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader: normal load, address wrap, empty load, abort,
// byte timeout and asynchronous reset mid-load.
module tb_inst_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0;
    logic [11:0] ld_start_adr = 12'd0;
    logic [12:0] ld_word_cnt = 13'd0;
    logic        ld_abort = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [11:0] ram_wadr;
    logic [31:0] ram_wdata;
    logic        ram_wen, ld_busy, cpu_stall, ld_done, ld_err;
    logic [31:0] ld_checksum;

    int vec = 0;
    int miss = 0;

    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    int done_cnt = 0;

    inst_ram_loader #(.IWIDTH(12), .TMO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_start_adr(ld_start_adr),
        .ld_word_cnt(ld_word_cnt), .ld_abort(ld_abort), .rx_data(rx_data),
        .rx_valid(rx_valid), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ld_busy(ld_busy), .cpu_stall(cpu_stall),
        .ld_done(ld_done), .ld_err(ld_err), .ld_checksum(ld_checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wen) begin
                wa_q.push_back(ram_wadr);
                wd_q.push_back(ram_wdata);
            end
            if (ld_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [11:0] adr, input logic [12:0] cnt);
        ld_start = 1'b1; ld_start_adr = adr; ld_word_cnt = cnt;
        tick(1);
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        tick(2);
        vec++; if (ram_wen !== 1'b0)      begin miss++; $display("FAIL rst_wen: got %b want 0", ram_wen); end
        vec++; if (ld_busy !== 1'b0)      begin miss++; $display("FAIL rst_busy: got %b want 0", ld_busy); end
        vec++; if (cpu_stall !== 1'b0)    begin miss++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        vec++; if (ld_done !== 1'b0)      begin miss++; $display("FAIL rst_done: got %b want 0", ld_done); end
        vec++; if (ld_err !== 1'b0)       begin miss++; $display("FAIL rst_err: got %b want 0", ld_err); end
        vec++; if (ld_checksum !== 32'd0) begin miss++; $display("FAIL rst_sum: got %h want 0", ld_checksum); end
        vec++; if (ram_wadr !== 12'd0)    begin miss++; $display("FAIL rst_wadr: got %h want 0", ram_wadr); end
        vec++; if (ram_wdata !== 32'd0)   begin miss++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
    endtask

    task automatic test_basic;
        logic [7:0] b [8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int w0 = wa_q.size();
        int d0 = done_cnt;
        send_byte(8'hFF);
        start(12'h010, 13'd2);
        vec++; if (ld_busy !== 1'b1)   begin miss++; $display("FAIL basic_busy: got %b want 1", ld_busy); end
        vec++; if (cpu_stall !== 1'b1) begin miss++; $display("FAIL basic_stall: got %b want 1", cpu_stall); end
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i]);
            if (i != 7) tick(1);
        end
        vec++; if (ram_wen !== 1'b1)           begin miss++; $display("FAIL basic_wen2: got %b want 1", ram_wen); end
        vec++; if (ram_wadr !== 12'h011)       begin miss++; $display("FAIL basic_wadr2: got %h want 011", ram_wadr); end
        vec++; if (ram_wdata !== 32'h00100093) begin miss++; $display("FAIL basic_wdata2: got %h want 00100093", ram_wdata); end
        vec++; if (ld_checksum !== 32'h001005A6) begin miss++; $display("FAIL basic_sum: got %h want 001005a6", ld_checksum); end
        vec++; if (ld_done !== 1'b0)           begin miss++; $display("FAIL basic_done_early: got %b want 0", ld_done); end
        tick(1);
        vec++; if (ld_done !== 1'b1) begin miss++; $display("FAIL basic_done: got %b want 1", ld_done); end
        vec++; if (ld_busy !== 1'b0) begin miss++; $display("FAIL basic_busy_off: got %b want 0", ld_busy); end
        vec++; if (ld_err !== 1'b0)  begin miss++; $display("FAIL basic_err: got %b want 0", ld_err); end
        tick(1);
        vec++; if (ld_done !== 1'b0) begin miss++; $display("FAIL basic_done_pulse: got %b want 0", ld_done); end
        vec++; if (wa_q.size() - w0 !== 2) begin miss++; $display("FAIL basic_nwr: got %0d want 2", wa_q.size() - w0); end
        if (wa_q.size() - w0 == 2) begin
            vec++; if (wa_q[w0] !== 12'h010)       begin miss++; $display("FAIL basic_wadr1: got %h want 010", wa_q[w0]); end
            vec++; if (wd_q[w0] !== 32'h00000513)  begin miss++; $display("FAIL basic_wdata1: got %h want 00000513", wd_q[w0]); end
        end
        vec++; if (done_cnt - d0 !== 1) begin miss++; $display("FAIL basic_ndone: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap_burst;
        int w0 = wa_q.size();
        int d0 = done_cnt;
        start(12'hFFF, 13'd2);
        for (int i = 0; i < 8; i++) send_byte(8'h11);
        for (int i = 0; i < 6 && done_cnt == d0; i++) tick(1);
        vec++; if (done_cnt - d0 !== 1) begin miss++; $display("FAIL wrap_done: got %0d want 1", done_cnt - d0); end
        vec++; if (wa_q.size() - w0 !== 2) begin miss++; $display("FAIL wrap_nwr: got %0d want 2", wa_q.size() - w0); end
        if (wa_q.size() - w0 == 2) begin
            vec++; if (wa_q[w0] !== 12'hFFF)       begin miss++; $display("FAIL wrap_adr0: got %h want fff", wa_q[w0]); end
            vec++; if (wa_q[w0+1] !== 12'h000)     begin miss++; $display("FAIL wrap_adr1: got %h want 000", wa_q[w0+1]); end
            vec++; if (wd_q[w0+1] !== 32'h11111111) begin miss++; $display("FAIL wrap_data: got %h want 11111111", wd_q[w0+1]); end
        end
        vec++; if (ld_checksum !== 32'h22222222) begin miss++; $display("FAIL wrap_sum: got %h want 22222222", ld_checksum); end
        tick(2);
    endtask

    task automatic test_zero_count;
        int w0 = wa_q.size();
        start(12'h055, 13'd0);
        vec++; if (ld_busy !== 1'b1) begin miss++; $display("FAIL zero_busy: got %b want 1", ld_busy); end
        vec++; if (ld_done !== 1'b0) begin miss++; $display("FAIL zero_done_early: got %b want 0", ld_done); end
        vec++; if (ld_checksum !== 32'd0) begin miss++; $display("FAIL zero_sum: got %h want 0", ld_checksum); end
        tick(1);
        vec++; if (ld_done !== 1'b1) begin miss++; $display("FAIL zero_done: got %b want 1", ld_done); end
        vec++; if (ld_busy !== 1'b0) begin miss++; $display("FAIL zero_busy_off: got %b want 0", ld_busy); end
        tick(2);
        vec++; if (wa_q.size() - w0 !== 0) begin miss++; $display("FAIL zero_nwr: got %0d want 0", wa_q.size() - w0); end
    endtask

    task automatic test_abort;
        int w0 = wa_q.size();
        int d0 = done_cnt;
        start(12'h100, 13'd3);
        send_byte(8'h01); send_byte(8'h02);
        start(12'h200, 13'd1);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        ld_abort = 1'b1; rx_data = 8'h07; rx_valid = 1'b1;
        tick(1);
        ld_abort = 1'b0; rx_valid = 1'b0;
        vec++; if (ld_busy !== 1'b0) begin miss++; $display("FAIL abort_busy: got %b want 0", ld_busy); end
        for (int i = 0; i < 4; i++) send_byte(8'h08);
        tick(3);
        vec++; if (wa_q.size() - w0 !== 1) begin miss++; $display("FAIL abort_nwr: got %0d want 1", wa_q.size() - w0); end
        if (wa_q.size() - w0 == 1) begin
            vec++; if (wa_q[w0] !== 12'h100)      begin miss++; $display("FAIL abort_adr: got %h want 100", wa_q[w0]); end
            vec++; if (wd_q[w0] !== 32'h04030201) begin miss++; $display("FAIL abort_data: got %h want 04030201", wd_q[w0]); end
        end
        vec++; if (done_cnt - d0 !== 0) begin miss++; $display("FAIL abort_ndone: got %0d want 0", done_cnt - d0); end
        vec++; if (ld_err !== 1'b0) begin miss++; $display("FAIL abort_err: got %b want 0", ld_err); end
        vec++; if (ld_checksum !== 32'h04030201) begin miss++; $display("FAIL abort_sum: got %h want 04030201", ld_checksum); end
    endtask

    task automatic test_timeout;
        int w0 = wa_q.size();
        int d0 = done_cnt;
        start(12'h020, 13'd1);
        send_byte(8'hAB); send_byte(8'hCD);
        tick(15);
        vec++; if (ld_err !== 1'b0)  begin miss++; $display("FAIL tmo_err_early: got %b want 0", ld_err); end
        vec++; if (ld_busy !== 1'b1) begin miss++; $display("FAIL tmo_busy: got %b want 1", ld_busy); end
        tick(1);
        vec++; if (ld_err !== 1'b1)  begin miss++; $display("FAIL tmo_err: got %b want 1", ld_err); end
        vec++; if (ld_busy !== 1'b0) begin miss++; $display("FAIL tmo_busy_off: got %b want 0", ld_busy); end
        send_byte(8'hEF); send_byte(8'h12);
        tick(2);
        vec++; if (wa_q.size() - w0 !== 0) begin miss++; $display("FAIL tmo_nwr: got %0d want 0", wa_q.size() - w0); end
        vec++; if (done_cnt - d0 !== 0) begin miss++; $display("FAIL tmo_ndone: got %0d want 0", done_cnt - d0); end
        vec++; if (ld_err !== 1'b1) begin miss++; $display("FAIL tmo_sticky: got %b want 1", ld_err); end
        start(12'h000, 13'd0);
        vec++; if (ld_err !== 1'b0) begin miss++; $display("FAIL tmo_clear: got %b want 0", ld_err); end
        tick(3);
    endtask

    task automatic test_reset_midload;
        int w0 = wa_q.size();
        start(12'h030, 13'd2);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
        vec++; if (ld_checksum !== 32'hDDCCBBAA) begin miss++; $display("FAIL rmid_sum_pre: got %h want ddccbbaa", ld_checksum); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (ld_busy !== 1'b0)      begin miss++; $display("FAIL rmid_busy: got %b want 0", ld_busy); end
        vec++; if (cpu_stall !== 1'b0)    begin miss++; $display("FAIL rmid_stall: got %b want 0", cpu_stall); end
        vec++; if (ld_checksum !== 32'd0) begin miss++; $display("FAIL rmid_sum: got %h want 0", ld_checksum); end
        vec++; if (ram_wdata !== 32'd0)   begin miss++; $display("FAIL rmid_wdata: got %h want 0", ram_wdata); end
        tick(2);
        rst_n = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        tick(3);
        vec++; if (wa_q.size() - w0 !== 1) begin miss++; $display("FAIL rmid_nwr: got %0d want 1", wa_q.size() - w0); end
        if (wa_q.size() - w0 == 1) begin
            vec++; if (wd_q[w0] !== 32'hDDCCBBAA) begin miss++; $display("FAIL rmid_data: got %h want ddccbbaa", wd_q[w0]); end
        end
        vec++; if (ld_busy !== 1'b0) begin miss++; $display("FAIL rmid_idle: got %b want 0", ld_busy); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_wrap_burst();
        test_zero_count();
        test_abort();
        test_timeout();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
